// File: rtl/single_cycle_cpu.sv
// Single-cycle 8-bit accumulator CPU: 4x8 register file, 16x8 data memory, Z/C flags.
// The instruction on ir_1/ir_2/ir_3 executes combinationally and commits on the next clk edge.
module single_cycle_cpu #(
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ir_1,
   input  logic [1:0] ir_2,
   input  logic [1:0] ir_3,
   output logic       memReadWrite
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
      OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_MOV = 4'h7,
      OP_SHL = 4'h8, OP_SHR = 4'h9, OP_LDI = 4'hA, OP_LD  = 4'hB,
      OP_ST  = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_CLR = 4'hF
   } op_e;

   logic [DATA_W-1:0] rf  [0:3];
   logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
   logic              zf;
   logic              cf;

   op_e               op;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] b_val;
   logic [AW-1:0]     addr;
   logic [DATA_W:0]   wide;
   logic [DATA_W-1:0] res_d;
   logic              rf_we;
   logic              mem_we;
   logic              zf_d;
   logic              cf_d;

   assign op    = op_e'(ir_1);
   assign a_val = rf[ir_2];
   assign b_val = rf[ir_3];
   // Only the low address bits of B select a word; the rest are ignored.
   assign addr  = b_val[AW-1:0];

   always_comb begin
      wide   = '0;
      res_d  = a_val;
      rf_we  = 1'b0;
      mem_we = 1'b0;
      zf_d   = zf;
      cf_d   = cf;
      case (op)
         OP_ADD: begin
            wide  = {1'b0, a_val} + {1'b0, b_val};
            res_d = wide[DATA_W-1:0];
            cf_d  = wide[DATA_W];
            rf_we = 1'b1;
         end
         OP_SUB: begin
            // MSB of the widened difference is the borrow (A < B unsigned).
            wide  = {1'b0, a_val} - {1'b0, b_val};
            res_d = wide[DATA_W-1:0];
            cf_d  = wide[DATA_W];
            rf_we = 1'b1;
         end
         OP_AND: begin
            res_d = a_val & b_val;
            cf_d  = 1'b0;
            rf_we = 1'b1;
         end
         OP_OR: begin
            res_d = a_val | b_val;
            cf_d  = 1'b0;
            rf_we = 1'b1;
         end
         OP_XOR: begin
            res_d = a_val ^ b_val;
            cf_d  = 1'b0;
            rf_we = 1'b1;
         end
         OP_NOT: begin
            res_d = ~b_val;
            cf_d  = 1'b0;
            rf_we = 1'b1;
         end
         OP_MOV: begin
            res_d = b_val;
            rf_we = 1'b1;
         end
         OP_SHL: begin
            res_d = {a_val[DATA_W-2:0], 1'b0};
            cf_d  = a_val[DATA_W-1];
            rf_we = 1'b1;
         end
         OP_SHR: begin
            res_d = {1'b0, a_val[DATA_W-1:1]};
            cf_d  = a_val[0];
            rf_we = 1'b1;
         end
         OP_LDI: begin
            res_d = {{(DATA_W-2){1'b0}}, ir_3};
            rf_we = 1'b1;
         end
         OP_LD: begin
            res_d = mem[addr];
            rf_we = 1'b1;
         end
         OP_ST: begin
            mem_we = 1'b1;
         end
         OP_INC: begin
            wide  = {1'b0, a_val} + ONE_W;
            res_d = wide[DATA_W-1:0];
            cf_d  = wide[DATA_W];
            rf_we = 1'b1;
         end
         OP_DEC: begin
            wide  = {1'b0, a_val} - ONE_W;
            res_d = wide[DATA_W-1:0];
            cf_d  = wide[DATA_W];
            rf_we = 1'b1;
         end
         OP_CLR: begin
            res_d = '0;
            cf_d  = 1'b0;
            rf_we = 1'b1;
         end
         default: begin
         end
      endcase
      // Every flag-updating op sets Z from its result; MOV/LDI/LD/ST/NOP leave it alone.
      if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                     OP_SHL, OP_SHR, OP_INC, OP_DEC, OP_CLR}) begin
         zf_d = (res_d == '0);
      end
   end

   assign memReadWrite = reset & mem_we;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            rf[i] <= '0;
         end
         for (int j = 0; j < MEM_DEPTH; j++) begin
            mem[j] <= '0;
         end
         zf <= 1'b0;
         cf <= 1'b0;
      end else begin
         if (rf_we) begin
            rf[ir_2] <= res_d;
         end
         if (mem_we) begin
            mem[addr] <= a_val;
         end
         zf <= zf_d;
         cf <= cf_d;
      end
   end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed instructions push expectations into a scoreboard
// queue; a monitor on the falling edge pops and compares them against the DUT.
module tb_single_cycle_cpu;

   logic       clk;
   logic       reset;
   logic [3:0] ir_1;
   logic [1:0] ir_2;
   logic [1:0] ir_3;
   logic       memReadWrite;

   single_cycle_cpu dut (
      .clk          (clk),
      .reset        (reset),
      .ir_1         (ir_1),
      .ir_2         (ir_2),
      .ir_3         (ir_3),
      .memReadWrite (memReadWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_RF  = 0;
   localparam int K_MEM = 1;
   localparam int K_ZF  = 2;
   localparam int K_CF  = 3;
   localparam int K_MRW = 4;

   typedef struct {
      string      name;
      int         kind;
      int         idx;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void exp_rf(input int i, input logic [7:0] v);
      exp_t e;
      e.name = $sformatf("rf[%0d]", i); e.kind = K_RF; e.idx = i; e.val = v;
      sb_q.push_back(e);
   endfunction

   function automatic void exp_mem(input int i, input logic [7:0] v);
      exp_t e;
      e.name = $sformatf("mem[%0d]", i); e.kind = K_MEM; e.idx = i; e.val = v;
      sb_q.push_back(e);
   endfunction

   function automatic void exp_flags(input logic z, input logic c);
      exp_t e;
      e.name = "zf"; e.kind = K_ZF; e.idx = 0; e.val = {7'd0, z};
      sb_q.push_back(e);
      e.name = "cf"; e.kind = K_CF; e.idx = 0; e.val = {7'd0, c};
      sb_q.push_back(e);
   endfunction

   function automatic void exp_mrw(input logic v);
      exp_t e;
      e.name = "memReadWrite"; e.kind = K_MRW; e.idx = 0; e.val = {7'd0, v};
      sb_q.push_back(e);
   endfunction

   function automatic void exp_all_clear();
      for (int i = 0; i < 4; i++) exp_rf(i, 8'h00);
      for (int i = 0; i < 16; i++) exp_mem(i, 8'h00);
      exp_flags(1'b0, 1'b0);
   endfunction

   // Drive one instruction just after a rising edge, then let it commit.
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic mrw);
      ir_1 = op;
      ir_2 = rd;
      ir_3 = rs;
      exp_mrw(mrw);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare everything pending at each falling edge.
   initial begin
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
               K_RF:    act = dut.rf[e.idx];
               K_MEM:   act = dut.mem[e.idx];
               K_ZF:    act = {7'd0, dut.zf};
               K_CF:    act = {7'd0, dut.cf};
               default: act = {7'd0, memReadWrite};
            endcase
            n_vec++;
            if (act !== e.val) begin
               n_err++;
               $display("FAIL %s: got %02h expected %02h at %0t", e.name, act, e.val, $time);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      // Reset with ST held: no write strobe, everything cleared.
      issue(4'hC, 2'd1, 2'd2, 1'b0);
      exp_all_clear();
      issue(4'hC, 2'd1, 2'd2, 1'b0);
      exp_all_clear();
      reset = 1'b1;

      issue(4'hA, 2'd1, 2'd3, 1'b0);  // LDI r1,3
      exp_rf(1, 8'h03);
      issue(4'hA, 2'd2, 2'd2, 1'b0);  // LDI r2,2
      exp_rf(2, 8'h02);
      issue(4'h1, 2'd1, 2'd2, 1'b0);  // ADD r1,r2
      exp_rf(1, 8'h05); exp_flags(1'b0, 1'b0);
      issue(4'h2, 2'd0, 2'd1, 1'b0);  // SUB r0,r1
      exp_rf(0, 8'hFB); exp_flags(1'b0, 1'b1);

      issue(4'hC, 2'd1, 2'd2, 1'b1);  // ST r1,[r2]
      exp_mem(2, 8'h05); exp_rf(1, 8'h05); exp_rf(2, 8'h02); exp_flags(1'b0, 1'b1);
      issue(4'hB, 2'd3, 2'd2, 1'b0);  // LD r3,[r2]
      exp_rf(3, 8'h05); exp_flags(1'b0, 1'b1);

      issue(4'hF, 2'd0, 2'd0, 1'b0);  // CLR r0
      exp_rf(0, 8'h00); exp_flags(1'b1, 1'b0);
      issue(4'hE, 2'd0, 2'd0, 1'b0);  // DEC r0
      exp_rf(0, 8'hFF); exp_flags(1'b0, 1'b1);
      issue(4'hD, 2'd0, 2'd0, 1'b0);  // INC r0
      exp_rf(0, 8'h00); exp_flags(1'b1, 1'b1);

      issue(4'hA, 2'd1, 2'd3, 1'b0);  // LDI r1,3
      exp_rf(1, 8'h03); exp_flags(1'b1, 1'b1);
      issue(4'h8, 2'd1, 2'd0, 1'b0);  // SHL: 06
      exp_rf(1, 8'h06); exp_flags(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) issue(4'h8, 2'd1, 2'd0, 1'b0);  // 0C..C0
      exp_rf(1, 8'hC0); exp_flags(1'b0, 1'b0);
      issue(4'h8, 2'd1, 2'd0, 1'b0);  // 7th SHL: 80
      exp_rf(1, 8'h80); exp_flags(1'b0, 1'b1);
      issue(4'h8, 2'd1, 2'd0, 1'b0);  // 00, carry out
      exp_rf(1, 8'h00); exp_flags(1'b1, 1'b1);
      issue(4'hA, 2'd1, 2'd1, 1'b0);  // LDI r1,1
      exp_rf(1, 8'h01);
      issue(4'h9, 2'd1, 2'd0, 1'b0);  // SHR r1
      exp_rf(1, 8'h00); exp_flags(1'b1, 1'b1);

      issue(4'hA, 2'd2, 2'd3, 1'b0);  // LDI r2,3
      exp_rf(2, 8'h03);
      issue(4'h3, 2'd3, 2'd2, 1'b0);  // AND r3,r2: 05&03
      exp_rf(3, 8'h01); exp_flags(1'b0, 1'b0);
      issue(4'h4, 2'd3, 2'd2, 1'b0);  // OR
      exp_rf(3, 8'h03); exp_flags(1'b0, 1'b0);
      issue(4'h5, 2'd3, 2'd2, 1'b0);  // XOR -> 0
      exp_rf(3, 8'h00); exp_flags(1'b1, 1'b0);
      issue(4'h6, 2'd0, 2'd3, 1'b0);  // NOT r0,r3
      exp_rf(0, 8'hFF); exp_flags(1'b0, 1'b0);
      issue(4'h7, 2'd1, 2'd0, 1'b0);  // MOV r1,r0
      exp_rf(1, 8'hFF); exp_flags(1'b0, 1'b0);
      issue(4'h1, 2'd1, 2'd0, 1'b0);  // ADD FF+FF
      exp_rf(1, 8'hFE); exp_flags(1'b0, 1'b1);
      issue(4'h7, 2'd2, 2'd1, 1'b0);  // MOV keeps flags
      exp_rf(2, 8'hFE); exp_flags(1'b0, 1'b1);

      issue(4'hA, 2'd3, 2'd2, 1'b0);  // LDI r3,2
      exp_rf(3, 8'h02);
      issue(4'hC, 2'd3, 2'd1, 1'b1);  // ST r3,[FE] -> mem[14]
      exp_mem(14, 8'h02); exp_mem(2, 8'h05);
      issue(4'hB, 2'd0, 2'd1, 1'b0);  // LD r0,[FE]
      exp_rf(0, 8'h02);
      issue(4'h1, 2'd3, 2'd3, 1'b0);  // ADD r3,r3 (rd==rs)
      exp_rf(3, 8'h04); exp_flags(1'b0, 1'b0);

      // Reset overrides an ST in the same cycle.
      reset = 1'b0;
      issue(4'hC, 2'd3, 2'd1, 1'b0);
      exp_all_clear();
      reset = 1'b1;
      issue(4'hC, 2'd3, 2'd1, 1'b1);
      exp_mem(0, 8'h00); exp_rf(3, 8'h00);
      issue(4'h0, 2'd0, 2'd0, 1'b0);
      exp_rf(0, 8'h00); exp_flags(1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
